// File: rtl/cc_bcd7seg_scanner.sv
// cc_bcd7seg_scanner
// Time-multiplexed driver for a 3-digit common-anode 7-segment display.
// Scans units -> tens -> hundreds, one digit per PRESCALE cycles, with optional
// leading-zero blanking. The BCD input is captured only at frame start so a
// digit never changes mid-frame. Segment and anode outputs are registered
// together so they always switch on the same edge.

module cc_bcd7seg_scanner #(
    parameter int unsigned PRESCALE = 50000,
    parameter int unsigned BLANK_LZ = 1
) (
    input  logic        CC_BCD7SEG_CLOCK_50,
    input  logic        CC_BCD7SEG_RESET_InLow,
    input  logic [11:0] CC_BCD7SEG_bcd_InBUS,
    output logic [6:0]  CC_BCD7SEG_seg_OutBUS,
    output logic [2:0]  CC_BCD7SEG_an_OutBUS,
    output logic        CC_BCD7SEG_frame_Out
);

    localparam int unsigned     CNT_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PRESCALE - 1);

    localparam logic [1:0] S_UNITS = 2'd0;
    localparam logic [1:0] S_TENS  = 2'd1;
    localparam logic [1:0] S_HUND  = 2'd2;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick;
    logic [1:0]       state_q, state_d;
    logic [11:0]      shadow_q, shadow_d;
    logic [6:0]       seg_q, seg_d;
    logic [2:0]       an_q, an_d;
    logic             frame_q, frame_d;

    logic [3:0]       nibble;
    logic [2:0]       an_sel;
    logic             blank;
    logic [6:0]       seg_dec;
    logic             hund_zero;
    logic             tens_zero;

    // Prescaler: free-running slot timer, tick on the last cycle of a slot
    always_comb begin
        tick  = (cnt_q == CNT_MAX);
        cnt_d = tick ? '0 : cnt_q + 1'b1;
    end

    // Scan sequencing; the shadow register is loaded only on the frame wrap
    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        frame_d  = 1'b0;
        if (tick) begin
            case (state_q)
                S_UNITS: state_d = S_TENS;
                S_TENS:  state_d = S_HUND;
                S_HUND: begin
                    state_d  = S_UNITS;
                    shadow_d = CC_BCD7SEG_bcd_InBUS;
                    frame_d  = 1'b1;
                end
                default: state_d = S_UNITS;
            endcase
        end
    end

    // Digit select, blanking and active-low segment decode
    always_comb begin
        hund_zero = (shadow_q[11:8] == 4'd0);
        tens_zero = (shadow_q[7:4] == 4'd0);
        nibble    = 4'd0;
        an_sel    = 3'b111;
        blank     = 1'b1;
        case (state_q)
            S_UNITS: begin
                nibble = shadow_q[3:0];
                an_sel = 3'b110;
                blank  = 1'b0;
            end
            S_TENS: begin
                nibble = shadow_q[7:4];
                an_sel = 3'b101;
                blank  = (BLANK_LZ != 0) && hund_zero && tens_zero;
            end
            S_HUND: begin
                nibble = shadow_q[11:8];
                an_sel = 3'b011;
                blank  = (BLANK_LZ != 0) && hund_zero;
            end
            default: begin
                nibble = 4'd0;
                an_sel = 3'b111;
                blank  = 1'b1;
            end
        endcase

        case (nibble)
            4'd0:    seg_dec = 7'b1000000;
            4'd1:    seg_dec = 7'b1111001;
            4'd2:    seg_dec = 7'b0100100;
            4'd3:    seg_dec = 7'b0110000;
            4'd4:    seg_dec = 7'b0011001;
            4'd5:    seg_dec = 7'b0010010;
            4'd6:    seg_dec = 7'b0000010;
            4'd7:    seg_dec = 7'b1111000;
            4'd8:    seg_dec = 7'b0000000;
            4'd9:    seg_dec = 7'b0010000;
            default: seg_dec = 7'b0111111; // invalid BCD shows a dash
        endcase

        if (blank) begin
            seg_d = 7'b1111111;
            an_d  = 3'b111;
        end else begin
            seg_d = seg_dec;
            an_d  = an_sel;
        end
    end

    // State and output registers with asynchronous active-low reset
    always_ff @(posedge CC_BCD7SEG_CLOCK_50 or negedge CC_BCD7SEG_RESET_InLow) begin
        if (!CC_BCD7SEG_RESET_InLow) begin
            cnt_q    <= '0;
            state_q  <= S_UNITS;
            shadow_q <= 12'h000;
            seg_q    <= 7'b1111111;
            an_q     <= 3'b111;
            frame_q  <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            state_q  <= state_d;
            shadow_q <= shadow_d;
            seg_q    <= seg_d;
            an_q     <= an_d;
            frame_q  <= frame_d;
        end
    end

    assign CC_BCD7SEG_seg_OutBUS = seg_q;
    assign CC_BCD7SEG_an_OutBUS  = an_q;
    assign CC_BCD7SEG_frame_Out  = frame_q;

endmodule

// File: tb/tb_cc_bcd7seg_scanner.sv
// Testbench for cc_bcd7seg_scanner. Two instances (blanking on and off) share
// clock, reset and input. A reference model derives the expected display from
// the number of clock edges since reset release: slot = (edges / P) % 3, and the
// input is captured on every edge whose index is a multiple of 3P.

module tb_cc_bcd7seg_scanner;

    localparam int P = 4;

    logic        clk;
    logic        rst_n;
    logic [11:0] bcd;
    logic [6:0]  seg_b, seg_n;
    logic [2:0]  an_b, an_n;
    logic        frame_b, frame_n;

    int checks = 0;
    int errors = 0;

    logic [6:0] seg_tab [0:15] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0111111, 7'b0111111,
        7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111
    };

    // Reference model state
    int          edges;
    logic [11:0] m_shadow;
    logic [6:0]  exp_seg_b, exp_seg_n;
    logic [2:0]  exp_an_b, exp_an_n;
    logic        exp_frame;

    cc_bcd7seg_scanner #(.PRESCALE(P), .BLANK_LZ(1)) u_dut_lz (
        .CC_BCD7SEG_CLOCK_50   (clk),
        .CC_BCD7SEG_RESET_InLow(rst_n),
        .CC_BCD7SEG_bcd_InBUS  (bcd),
        .CC_BCD7SEG_seg_OutBUS (seg_b),
        .CC_BCD7SEG_an_OutBUS  (an_b),
        .CC_BCD7SEG_frame_Out  (frame_b)
    );

    cc_bcd7seg_scanner #(.PRESCALE(P), .BLANK_LZ(0)) u_dut_nolz (
        .CC_BCD7SEG_CLOCK_50   (clk),
        .CC_BCD7SEG_RESET_InLow(rst_n),
        .CC_BCD7SEG_bcd_InBUS  (bcd),
        .CC_BCD7SEG_seg_OutBUS (seg_n),
        .CC_BCD7SEG_an_OutBUS  (an_n),
        .CC_BCD7SEG_frame_Out  (frame_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit f_blanked(int slot, logic [11:0] v, bit lz);
        return lz && ((slot == 2 && v[11:8] == 4'd0) || (slot == 1 && v[11:4] == 8'd0));
    endfunction

    function automatic logic [6:0] f_seg(int slot, logic [11:0] v, bit lz);
        logic [3:0] nib;
        nib = v[slot*4 +: 4];
        if (f_blanked(slot, v, lz)) return 7'b1111111;
        return seg_tab[nib];
    endfunction

    function automatic logic [2:0] f_an(int slot, logic [11:0] v, bit lz);
        logic [2:0] a;
        a = 3'b111;
        if (!f_blanked(slot, v, lz)) a[slot] = 1'b0;
        return a;
    endfunction

    // Model: outputs after an edge reflect the slot and shadow before it
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edges     <= 0;
            m_shadow  <= 12'h000;
            exp_seg_b <= 7'b1111111;
            exp_seg_n <= 7'b1111111;
            exp_an_b  <= 3'b111;
            exp_an_n  <= 3'b111;
            exp_frame <= 1'b0;
        end else begin
            exp_seg_b <= f_seg((edges / P) % 3, m_shadow, 1'b1);
            exp_an_b  <= f_an((edges / P) % 3, m_shadow, 1'b1);
            exp_seg_n <= f_seg((edges / P) % 3, m_shadow, 1'b0);
            exp_an_n  <= f_an((edges / P) % 3, m_shadow, 1'b0);
            exp_frame <= ((edges + 1) % (3 * P) == 0);
            if ((edges + 1) % (3 * P) == 0) m_shadow <= bcd;
            edges <= edges + 1;
        end
    end

    task automatic test_reset();
        rst_n = 1'b1;
        bcd   = 12'h000;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({seg_b, an_b, frame_b, seg_n, an_n, frame_n} !== {7'h7F, 3'h7, 1'b0, 7'h7F, 3'h7, 1'b0})
            begin
            errors++;
            $display("FAIL reset_async seg=%b/%b an=%b/%b frame=%b/%b want 1111111 111 0",
                     seg_b, seg_n, an_b, an_n, frame_b, frame_n);
        end
        repeat (3) @(negedge clk);
        checks++;
        if ({seg_b, an_b, frame_b} !== {7'h7F, 3'h7, 1'b0}) begin
            errors++;
            $display("FAIL reset_held seg=%b an=%b frame=%b want 1111111 111 0",
                     seg_b, an_b, frame_b);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (an_b !== 3'b110 || seg_b !== 7'b1000000) begin
            errors++;
            $display("FAIL reset_first_edge seg=%b an=%b want 1000000 110", seg_b, an_b);
        end
        repeat (12) begin
            @(negedge clk);
            checks++;
            if ({seg_b, an_b, frame_b, seg_n, an_n} !==
                {exp_seg_b, exp_an_b, exp_frame, exp_seg_n, exp_an_n}) begin
                errors++;
                $display("FAIL reset_idle e=%0d seg=%b/%b an=%b/%b frame=%b want %b/%b %b/%b %b",
                         edges, seg_b, seg_n, an_b, an_n, frame_b,
                         exp_seg_b, exp_seg_n, exp_an_b, exp_an_n, exp_frame);
            end
        end
    endtask

    task automatic test_full_value();
        int last_frame;
        last_frame = -1;
        bcd = 12'h255;
        for (int i = 0; i < 48; i++) begin
            @(negedge clk);
            checks++;
            if ({seg_b, an_b, frame_b, seg_n, an_n, frame_n} !==
                {exp_seg_b, exp_an_b, exp_frame, exp_seg_n, exp_an_n, exp_frame}) begin
                errors++;
                $display("FAIL full_value e=%0d seg=%b/%b an=%b/%b frame=%b/%b want %b/%b %b/%b %b",
                         edges, seg_b, seg_n, an_b, an_n, frame_b, frame_n,
                         exp_seg_b, exp_seg_n, exp_an_b, exp_an_n, exp_frame);
            end
            if (frame_b === 1'b1) begin
                if (last_frame >= 0) begin
                    checks++;
                    if (i - last_frame != 3 * P) begin
                        errors++;
                        $display("FAIL frame_spacing got=%0d want=%0d", i - last_frame, 3 * P);
                    end
                end
                last_frame = i;
            end
        end
    endtask

    task automatic test_blanking();
        logic [11:0] vals [0:1];
        vals[0] = 12'h007;
        vals[1] = 12'h070;
        for (int v = 0; v < 2; v++) begin
            bcd = vals[v];
            repeat (30) begin
                @(negedge clk);
                checks++;
                if ({seg_b, an_b, frame_b, seg_n, an_n} !==
                    {exp_seg_b, exp_an_b, exp_frame, exp_seg_n, exp_an_n}) begin
                    errors++;
                    $display("FAIL blanking v=%h seg=%b/%b an=%b/%b frame=%b want %b/%b %b/%b %b",
                             vals[v], seg_b, seg_n, an_b, an_n, frame_b,
                             exp_seg_b, exp_seg_n, exp_an_b, exp_an_n, exp_frame);
                end
            end
        end
    endtask

    task automatic test_tear_free();
        int pulses;
        bit seen;
        bcd    = 12'h123;
        pulses = 0;
        seen   = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            checks++;
            if ({seg_b, an_b, frame_b} !== {exp_seg_b, exp_an_b, exp_frame}) begin
                errors++;
                $display("FAIL tear_wait seg=%b an=%b frame=%b want %b %b %b",
                         seg_b, an_b, frame_b, exp_seg_b, exp_an_b, exp_frame);
            end
            if (frame_b === 1'b1) pulses++;
            if (pulses == 2) seen = 1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL tear_frame_timeout pulses=%0d want 2", pulses);
        end
        // 123 now captured; move into the middle of the tens slot, then change input
        repeat (6) @(negedge clk);
        bcd = 12'h456;
        repeat (4) @(negedge clk);
        checks++;
        if (seg_b !== 7'b1111001 || an_b !== 3'b011) begin
            errors++;
            $display("FAIL tear_hold_hund seg=%b an=%b want 1111001 011", seg_b, an_b);
        end
        repeat (28) begin
            @(negedge clk);
            checks++;
            if ({seg_b, an_b, frame_b, seg_n, an_n} !==
                {exp_seg_b, exp_an_b, exp_frame, exp_seg_n, exp_an_n}) begin
                errors++;
                $display("FAIL tear_free e=%0d seg=%b/%b an=%b/%b frame=%b want %b/%b %b/%b %b",
                         edges, seg_b, seg_n, an_b, an_n, frame_b,
                         exp_seg_b, exp_seg_n, exp_an_b, exp_an_n, exp_frame);
            end
        end
    endtask

    task automatic test_invalid();
        bcd = 12'h0A3;
        repeat (30) begin
            @(negedge clk);
            checks++;
            if ({seg_b, an_b, frame_b, seg_n, an_n} !==
                {exp_seg_b, exp_an_b, exp_frame, exp_seg_n, exp_an_n}) begin
                errors++;
                $display("FAIL invalid seg=%b/%b an=%b/%b frame=%b want %b/%b %b/%b %b",
                         seg_b, seg_n, an_b, an_n, frame_b,
                         exp_seg_b, exp_seg_n, exp_an_b, exp_an_n, exp_frame);
            end
        end
    endtask

    task automatic test_random();
        int hold;
        for (int k = 0; k < 40; k++) begin
            for (int d = 0; d < 3; d++)
                bcd[d*4 +: 4] = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            hold = $urandom_range(1, 20);
            repeat (hold) begin
                @(negedge clk);
                checks++;
                if ({seg_b, an_b, frame_b, seg_n, an_n, frame_n} !==
                    {exp_seg_b, exp_an_b, exp_frame, exp_seg_n, exp_an_n, exp_frame}) begin
                    errors++;
                    $display("FAIL random e=%0d seg=%b/%b an=%b/%b frame=%b/%b want %b/%b %b/%b %b",
                             edges, seg_b, seg_n, an_b, an_n, frame_b, frame_n,
                             exp_seg_b, exp_seg_n, exp_an_b, exp_an_n, exp_frame);
                end
            end
        end
    endtask

    task automatic test_async_reset_mid();
        bit found;
        int cyc;
        bit got;
        bcd   = 12'h987;
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (edges > 0 && ((edges - 1) / P) % 3 == 2 && an_b === 3'b011) found = 1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL mid_reset_find no hundreds slot seen");
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({seg_b, an_b, frame_b, seg_n, an_n} !== {7'h7F, 3'h7, 1'b0, 7'h7F, 3'h7}) begin
            errors++;
            $display("FAIL mid_reset_force seg=%b/%b an=%b/%b frame=%b want 1111111 111 0",
                     seg_b, seg_n, an_b, an_n, frame_b);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        got   = 0;
        cyc   = 0;
        for (int i = 1; i <= 40 && !got; i++) begin
            @(negedge clk);
            checks++;
            if ({seg_b, an_b, frame_b, seg_n, an_n} !==
                {exp_seg_b, exp_an_b, exp_frame, exp_seg_n, exp_an_n}) begin
                errors++;
                $display("FAIL mid_reset_scan i=%0d seg=%b/%b an=%b/%b frame=%b want %b/%b %b/%b %b",
                         i, seg_b, seg_n, an_b, an_n, frame_b,
                         exp_seg_b, exp_seg_n, exp_an_b, exp_an_n, exp_frame);
            end
            if (frame_b === 1'b1) begin
                got = 1;
                cyc = i;
            end
        end
        checks++;
        if (cyc != 3 * P) begin
            errors++;
            $display("FAIL mid_reset_first_frame got=%0d want=%0d", cyc, 3 * P);
        end
        repeat (14) begin
            @(negedge clk);
            checks++;
            if ({seg_b, an_b, frame_b} !== {exp_seg_b, exp_an_b, exp_frame}) begin
                errors++;
                $display("FAIL mid_reset_after seg=%b an=%b frame=%b want %b %b %b",
                         seg_b, an_b, frame_b, exp_seg_b, exp_an_b, exp_frame);
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_value();
        test_blanking();
        test_tear_free();
        test_invalid();
        test_random();
        test_async_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
